// File: rtl/iic_cfg_pkg.sv
`default_nettype none
//==============================================================================
// Module   : iic_cfg_pkg
// Brief    : Shared widths and FSM state encoding for the I2C config sequencer.
// Revision : 1.0 - initial release
//==============================================================================
package iic_cfg_pkg;

   localparam int TBL_W  = 24;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int IDX_W  = 8;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WAIT_PWR = 4'd1,
      ST_FETCH    = 4'd2,
      ST_WR       = 4'd3,
      ST_WR_WAIT  = 4'd4,
      ST_RD       = 4'd5,
      ST_RD_WAIT  = 4'd6,
      ST_CHECK    = 4'd7,
      ST_NEXT     = 4'd8,
      ST_DONE     = 4'd9,
      ST_ERR      = 4'd10
   } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/iic_cfg_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : iic_cfg_sequencer
// Brief    : Walks a register table through one iic_driver: write, optional
//            read-back compare, bounded retries, sticky done/error reporting.
// Revision : 1.0 - initial release
//==============================================================================
module iic_cfg_sequencer
   import iic_cfg_pkg::*;
#(
   parameter int REG_NUM   = 8,
   parameter int PWR_DLY   = 20_000,
   parameter int MAX_RETRY = 3,
   parameter int VERIFY    = 1,
   parameter int BIT_CTRL  = 1,
   parameter int TIMEOUT   = 65_535
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              cfg_start,
   output logic [IDX_W-1:0]  tbl_idx,
   input  logic [TBL_W-1:0]  tbl_data,
   output logic              bit_ctrl,
   output logic              iic_exe,
   output logic              iic_rw_ctrl,
   output logic [ADDR_W-1:0] iic_addr,
   output logic [DATA_W-1:0] iic_data_in,
   input  logic [DATA_W-1:0] iic_data_out,
   input  logic              iic_ack,
   input  logic              iic_done,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic [IDX_W-1:0]  err_idx
);

   localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(REG_NUM - 1);
   localparam logic [2:0]       c_max_retry = 3'(MAX_RETRY);
   localparam logic [31:0]      c_pwr_last  = (PWR_DLY > 0) ? 32'(PWR_DLY - 1) : 32'd0;
   localparam logic [31:0]      c_timeout   = 32'(TIMEOUT);

   cfg_state_t        r_state;
   logic [31:0]       r_pwr_cnt;
   logic [31:0]       r_to_cnt;
   logic [2:0]        r_retry;
   logic [ADDR_W-1:0] r_reg_addr;
   logic [DATA_W-1:0] r_reg_data;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_done_q;

   logic w_done_rise;
   logic w_timeout;
   logic w_waiting;
   logic w_fail;

   assign bit_ctrl    = (BIT_CTRL != 0);
   assign w_done_rise = iic_done & ~r_done_q;
   assign w_timeout   = (r_to_cnt >= c_timeout);
   assign w_waiting   = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);

   // One failure flag shared by NACK, timeout and read-back mismatch so the
   // retry/abort decision lives in exactly one place.
   assign w_fail = (w_waiting && ((w_done_rise && iic_ack) || (!w_done_rise && w_timeout)))
                || ((r_state == ST_CHECK) && (r_rd_data != r_reg_data));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state     <= ST_WAIT_PWR;
         r_pwr_cnt   <= '0;
         r_to_cnt    <= '0;
         r_retry     <= '0;
         r_reg_addr  <= '0;
         r_reg_data  <= '0;
         r_rd_data   <= '0;
         r_done_q    <= 1'b0;
         tbl_idx     <= '0;
         iic_exe     <= 1'b0;
         iic_rw_ctrl <= 1'b0;
         iic_addr    <= '0;
         iic_data_in <= '0;
         cfg_busy    <= 1'b0;
         cfg_done    <= 1'b0;
         cfg_err     <= 1'b0;
         err_idx     <= '0;
      end else begin
         r_done_q <= iic_done;
         iic_exe  <= 1'b0;

         if (w_fail) begin
            if (r_retry < c_max_retry) begin
               r_retry <= r_retry + 3'd1;
               r_state <= ST_WR;
            end else begin
               err_idx  <= tbl_idx;
               cfg_err  <= 1'b1;
               cfg_busy <= 1'b0;
               r_state  <= ST_ERR;
            end
         end else begin
            case (r_state)
               ST_IDLE, ST_DONE, ST_ERR: begin
                  if (cfg_start) begin
                     cfg_done  <= 1'b0;
                     cfg_err   <= 1'b0;
                     err_idx   <= '0;
                     tbl_idx   <= '0;
                     r_pwr_cnt <= '0;
                     cfg_busy  <= 1'b1;
                     r_state   <= ST_WAIT_PWR;
                  end
               end
               ST_WAIT_PWR: begin
                  cfg_busy <= 1'b1;
                  if (r_pwr_cnt >= c_pwr_last) r_state <= ST_FETCH;
                  else                         r_pwr_cnt <= r_pwr_cnt + 32'd1;
               end
               ST_FETCH: begin
                  r_reg_addr <= tbl_data[TBL_W-1 -: ADDR_W];
                  r_reg_data <= tbl_data[DATA_W-1:0];
                  r_retry    <= '0;
                  r_state    <= ST_WR;
               end
               ST_WR: begin
                  iic_exe     <= 1'b1;
                  iic_rw_ctrl <= 1'b0;
                  iic_addr    <= r_reg_addr;
                  iic_data_in <= r_reg_data;
                  r_to_cnt    <= '0;
                  r_state     <= ST_WR_WAIT;
               end
               ST_WR_WAIT: begin
                  if (w_done_rise) r_state <= (VERIFY != 0) ? ST_RD : ST_NEXT;
                  else             r_to_cnt <= r_to_cnt + 32'd1;
               end
               ST_RD: begin
                  iic_exe     <= 1'b1;
                  iic_rw_ctrl <= 1'b1;
                  iic_addr    <= r_reg_addr;
                  r_to_cnt    <= '0;
                  r_state     <= ST_RD_WAIT;
               end
               ST_RD_WAIT: begin
                  if (w_done_rise) begin
                     r_rd_data <= iic_data_out;
                     r_state   <= ST_CHECK;
                  end else begin
                     r_to_cnt <= r_to_cnt + 32'd1;
                  end
               end
               ST_CHECK: r_state <= ST_NEXT;
               ST_NEXT: begin
                  if (tbl_idx == c_last_idx) begin
                     cfg_done <= 1'b1;
                     cfg_busy <= 1'b0;
                     r_state  <= ST_DONE;
                  end else begin
                     tbl_idx <= tbl_idx + 8'd1;
                     r_state <= ST_FETCH;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iic_cfg_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_iic_cfg_sequencer
// Brief    : Scoreboard bench: driver model plus expected-transaction queues.
// Revision : 1.0 - initial release
//==============================================================================
module tb_iic_cfg_sequencer;

   localparam int REG_NUM   = 4;
   localparam int PWR_DLY   = 100;
   localparam int MAX_RETRY = 3;
   localparam int TIMEOUT   = 200;
   localparam int LAT       = 5;

   typedef struct packed {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
   } txn_t;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic        sys_rst   = 1'b1;
   logic        rst_nv    = 1'b1;
   logic        cfg_start = 1'b0;

   logic [7:0]  tbl_idx, err_idx, iic_data_in, iic_data_out;
   logic [23:0] tbl_data;
   logic [15:0] iic_addr;
   logic        bit_ctrl, iic_exe, iic_rw_ctrl, iic_ack, iic_done;
   logic        cfg_busy, cfg_done, cfg_err;

   logic [7:0]  nv_tbl_idx, nv_err_idx, nv_data_in;
   logic [23:0] nv_tbl_data;
   logic [15:0] nv_addr;
   logic        nv_bit_ctrl, nv_exe, nv_rw, nv_done;
   logic        nv_busy, nv_cfg_done, nv_cfg_err;

   int total = 0;
   int bad   = 0;
   txn_t exp_q[$];
   txn_t nv_q[$];

   bit hang      = 1'b0;
   bit nack_once = 1'b0;
   bit bad_rb    = 1'b0;

   function automatic logic [23:0] lut(input logic [7:0] idx);
      case (idx)
         8'd0:    return 24'h3008_82;
         8'd1:    return 24'h3103_C9;
         8'd2:    return 24'h3017_7F;
         8'd3:    return 24'h4300_30;
         default: return 24'h0000_00;
      endcase
   endfunction

   assign tbl_data    = lut(tbl_idx);
   assign nv_tbl_data = lut(nv_tbl_idx);

   iic_cfg_sequencer #(
      .REG_NUM(REG_NUM), .PWR_DLY(PWR_DLY), .MAX_RETRY(MAX_RETRY),
      .VERIFY(1), .BIT_CTRL(1), .TIMEOUT(TIMEOUT)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start),
      .tbl_idx(tbl_idx), .tbl_data(tbl_data), .bit_ctrl(bit_ctrl),
      .iic_exe(iic_exe), .iic_rw_ctrl(iic_rw_ctrl), .iic_addr(iic_addr),
      .iic_data_in(iic_data_in), .iic_data_out(iic_data_out), .iic_ack(iic_ack),
      .iic_done(iic_done), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
      .cfg_err(cfg_err), .err_idx(err_idx)
   );

   iic_cfg_sequencer #(
      .REG_NUM(REG_NUM), .PWR_DLY(PWR_DLY), .MAX_RETRY(MAX_RETRY),
      .VERIFY(0), .BIT_CTRL(1), .TIMEOUT(TIMEOUT)
   ) dut_nv (
      .sys_clk(sys_clk), .sys_rst(rst_nv), .cfg_start(1'b0),
      .tbl_idx(nv_tbl_idx), .tbl_data(nv_tbl_data), .bit_ctrl(nv_bit_ctrl),
      .iic_exe(nv_exe), .iic_rw_ctrl(nv_rw), .iic_addr(nv_addr),
      .iic_data_in(nv_data_in), .iic_data_out(8'h00), .iic_ack(1'b0),
      .iic_done(nv_done), .cfg_busy(nv_busy), .cfg_done(nv_cfg_done),
      .cfg_err(nv_cfg_err), .err_idx(nv_err_idx)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Slave model: done pulse LAT+1 cycles after exe; reads return the last
   // written byte, optionally corrupted for register 0x3103.
   logic       pend, pend_rw, nack_used;
   logic [15:0] pend_addr;
   logic [7:0] last_wr;
   int         lat_cnt;
   always @(posedge sys_clk) begin
      if (sys_rst) begin
         pend <= 1'b0; iic_done <= 1'b0; iic_ack <= 1'b0; iic_data_out <= 8'h00;
         nack_used <= 1'b0; lat_cnt <= 0; pend_rw <= 1'b0; pend_addr <= 16'h0;
         last_wr <= 8'h00;
      end else begin
         iic_done <= 1'b0;
         if (iic_exe && !hang) begin
            pend <= 1'b1; lat_cnt <= LAT; pend_rw <= iic_rw_ctrl; pend_addr <= iic_addr;
            if (!iic_rw_ctrl) last_wr <= iic_data_in;
         end else if (pend) begin
            if (lat_cnt == 0) begin
               pend     <= 1'b0;
               iic_done <= 1'b1;
               iic_ack  <= !pend_rw && nack_once && !nack_used && (pend_addr == 16'h3017);
               if (!pend_rw && nack_once && (pend_addr == 16'h3017)) nack_used <= 1'b1;
               iic_data_out <= (bad_rb && pend_addr == 16'h3103) ? 8'h00 : last_wr;
            end else begin
               lat_cnt <= lat_cnt - 1;
            end
         end
      end
   end

   logic nv_pend;
   int   nv_cnt;
   always @(posedge sys_clk) begin
      if (rst_nv) begin
         nv_pend <= 1'b0; nv_done <= 1'b0; nv_cnt <= 0;
      end else begin
         nv_done <= 1'b0;
         if (nv_exe) begin
            nv_pend <= 1'b1; nv_cnt <= 2;
         end else if (nv_pend) begin
            if (nv_cnt == 0) begin nv_done <= 1'b1; nv_pend <= 1'b0; end
            else nv_cnt <= nv_cnt - 1;
         end
      end
   end

   always @(negedge sys_clk) begin
      if (iic_exe) begin
         bit   have;
         txn_t e;
         have = (exp_q.size() != 0);
         chk("exe_expected", 32'(have), 32'd1);
         if (have) begin
            e = exp_q.pop_front();
            if (!e.rw) chk("wr_txn", 32'({iic_rw_ctrl, iic_addr, iic_data_in}), 32'(e));
            else       chk("rd_txn", 32'({iic_rw_ctrl, iic_addr}), 32'({e.rw, e.addr}));
         end
      end
      if (nv_exe) begin
         bit   have;
         txn_t e;
         have = (nv_q.size() != 0);
         chk("nv_exe_expected", 32'(have), 32'd1);
         if (have) begin
            e = nv_q.pop_front();
            chk("nv_wr_txn", 32'({nv_rw, nv_addr, nv_data_in}), 32'(e));
         end
      end
   end

   task automatic push_entry(input int idx, input bit rd);
      txn_t t;
      logic [23:0] v;
      v = lut(8'(idx));
      t = {1'b0, v[23:8], v[7:0]};
      exp_q.push_back(t);
      if (rd) begin
         t.rw = 1'b1;
         exp_q.push_back(t);
      end
   endtask

   task automatic push_all();
      for (int i = 0; i < REG_NUM; i++) push_entry(i, 1'b1);
   endtask

   task automatic pulse_reset();
      @(negedge sys_clk);
      sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic wait_end(input string nm, input int budget);
      int n = 0;
      while (!(cfg_done || cfg_err) && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      chk({nm, "_finished"}, 32'(cfg_done || cfg_err), 32'd1);
   endtask

   task automatic chk_end(input string nm, input bit d, input bit e, input int eidx);
      repeat (40) @(negedge sys_clk);
      chk({nm, "_cfg_done"}, 32'(cfg_done), 32'(d));
      chk({nm, "_cfg_err"},  32'(cfg_err),  32'(e));
      chk({nm, "_busy"},     32'(cfg_busy), 32'd0);
      if (e) chk({nm, "_err_idx"}, 32'(err_idx), 32'(eidx));
      chk({nm, "_q_left"},   32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge sys_clk);
      chk("rst_outputs", 32'({tbl_idx, iic_exe, iic_rw_ctrl, cfg_busy, cfg_done, cfg_err, err_idx}), 32'd0);
      chk("rst_addr_data", 32'({iic_addr, iic_data_in}), 32'd0);
      chk("rst_bit_ctrl", 32'(bit_ctrl), 32'd1);

      // 1: full verified run, then a cfg_start rerun from DONE
      push_all();
      pulse_reset();
      repeat (10) @(negedge sys_clk);
      chk("t1_busy", 32'(cfg_busy), 32'd1);
      wait_end("t1", 2000);
      chk_end("t1", 1'b1, 1'b0, 0);
      push_all();
      cfg_start = 1'b1;
      @(negedge sys_clk);
      cfg_start = 1'b0;
      chk("t1r_done_clr", 32'({cfg_done, cfg_busy}), 32'b01);
      wait_end("t1r", 2000);
      chk_end("t1r", 1'b1, 1'b0, 0);

      // 3: one NACK on the first write of entry 2
      nack_once = 1'b1;
      push_entry(0, 1); push_entry(1, 1); push_entry(2, 0); push_entry(2, 1); push_entry(3, 1);
      pulse_reset();
      wait_end("t3", 2000);
      chk_end("t3", 1'b1, 1'b0, 0);
      nack_once = 1'b0;

      // 4: entry 1 always reads back 0x00
      bad_rb = 1'b1;
      push_entry(0, 1);
      for (int i = 0; i <= MAX_RETRY; i++) push_entry(1, 1);
      pulse_reset();
      wait_end("t4", 2000);
      chk_end("t4", 1'b0, 1'b1, 1);
      bad_rb = 1'b0;

      // 5: driver never completes
      hang = 1'b1;
      for (int i = 0; i <= MAX_RETRY; i++) push_entry(0, 0);
      pulse_reset();
      wait_end("t5", 3000);
      chk_end("t5", 1'b0, 1'b1, 0);
      hang = 1'b0;

      // 6: reset during RD_WAIT of entry 2, then cfg_start while busy
      push_entry(0, 1); push_entry(1, 1); push_entry(2, 1);
      pulse_reset();
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("t6_reach_rd2", 32'(exp_q.size()), 32'd0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      push_all();
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      n = 0;
      while (!iic_exe && n < 1000) begin
         @(negedge sys_clk);
         n++;
         cfg_start = (n == 20);
         if (n == 20) chk("t6_busy_at_start", 32'(cfg_busy), 32'd1);
      end
      cfg_start = 1'b0;
      chk("t6_first_exe_delay", 32'(n >= PWR_DLY && n <= PWR_DLY + 6), 32'd1);
      wait_end("t6", 2000);
      chk_end("t6", 1'b1, 1'b0, 0);

      // 2: write-only instance
      for (int i = 0; i < REG_NUM; i++) begin
         logic [23:0] v;
         v = lut(8'(i));
         nv_q.push_back({1'b0, v[23:8], v[7:0]});
      end
      @(negedge sys_clk);
      rst_nv = 1'b0;
      n = 0;
      while (!(nv_cfg_done || nv_cfg_err) && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      repeat (20) @(negedge sys_clk);
      chk("t2_flags", 32'({nv_cfg_done, nv_cfg_err, nv_busy}), 32'b100);
      chk("t2_q_left", 32'(nv_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
